// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller.
// Walks a fixed six-phase cycle (G1, Y1, AR1, G2, Y2, AR2), shortens a green
// once its minimum has run and the other road has a latched request, and
// exports the seconds left in the current phase in binary and as BCD digits.
module traffic_phase_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req1,
    input  logic       req2,
    output logic       R1_led,
    output logic       Y1_led,
    output logic       G1_led,
    output logic       R2_led,
    output logic       Y2_led,
    output logic       G2_led,
    output logic [2:0] phase,
    output logic [6:0] remain,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       tick
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    GMIN_C     = 7'(GREEN_MIN);
    localparam logic [6:0]    GMAX_C     = 7'(GREEN_MAX);
    localparam logic [6:0]    YEL_C      = 7'(YELLOW_T);
    localparam logic [6:0]    ARED_C     = 7'(ALLRED_T);

    typedef enum logic [2:0] {
        PH_G1  = 3'd0,
        PH_Y1  = 3'd1,
        PH_AR1 = 3'd2,
        PH_G2  = 3'd3,
        PH_Y2  = 3'd4,
        PH_AR2 = 3'd5
    } phase_e;

    // Lamp vector layout: {R1, Y1, G1, R2, Y2, G2}.
    localparam logic [5:0] LAMPS_ALLRED = 6'b100_100;

    // Length of a phase in seconds; unknown codes are treated as all-red.
    function automatic logic [6:0] phase_duration(input phase_e ph);
        logic [6:0] dur;
        case (ph)
            PH_G1, PH_G2: dur = GMAX_C;
            PH_Y1, PH_Y2: dur = YEL_C;
            default:      dur = ARED_C;
        endcase
        return dur;
    endfunction

    // Phase that follows ph in the fixed rotation; unknown codes recover to AR2.
    function automatic phase_e phase_succ(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_G1:   nxt = PH_Y1;
            PH_Y1:   nxt = PH_AR1;
            PH_AR1:  nxt = PH_G2;
            PH_G2:   nxt = PH_Y2;
            PH_Y2:   nxt = PH_AR2;
            PH_AR2:  nxt = PH_G1;
            default: nxt = PH_AR2;
        endcase
        return nxt;
    endfunction

    // One lamp per road, all-red as the safe fallback.
    function automatic logic [5:0] lamp_decode(input phase_e ph);
        logic [5:0] lamps;
        case (ph)
            PH_G1:   lamps = 6'b001_100;
            PH_Y1:   lamps = 6'b010_100;
            PH_G2:   lamps = 6'b100_001;
            PH_Y2:   lamps = 6'b100_010;
            default: lamps = LAMPS_ALLRED;
        endcase
        return lamps;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    phase_e        phase_q, phase_d;
    logic [6:0]    sec_cnt_q, sec_cnt_d;
    logic [6:0]    remain_q, remain_d;
    logic [5:0]    lamps_q, lamps_d;
    logic          pend1_q, pend1_d;
    logic          pend2_q, pend2_d;
    logic [6:0]    n_s;
    logic          adv_s;

    // Prescaler wraps after TICK_DIV-1; tick is registered so it is high while the prescaler holds TICK_DIV-1.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
        tick_d = (presc_d == PRESC_LAST);
    end

    // Phase sequencing: all exit checks use the count as it will be after this second.
    always_comb begin
        n_s       = sec_cnt_q + 7'd1;
        adv_s     = 1'b0;
        phase_d   = phase_q;
        sec_cnt_d = sec_cnt_q;
        case (phase_q)
            PH_G1:          adv_s = (n_s >= GMAX_C) || ((n_s >= GMIN_C) && pend2_q);
            PH_G2:          adv_s = (n_s >= GMAX_C) || ((n_s >= GMIN_C) && pend1_q);
            PH_Y1, PH_Y2:   adv_s = (n_s >= YEL_C);
            PH_AR1, PH_AR2: adv_s = (n_s >= ARED_C);
            default:        adv_s = 1'b1;
        endcase
        if (phase_q > PH_AR2) begin
            // Illegal code: fall back to all-red immediately, tick or not.
            phase_d   = PH_AR2;
            sec_cnt_d = 7'd0;
        end else if (tick_q) begin
            if (adv_s) begin
                phase_d   = phase_succ(phase_q);
                sec_cnt_d = 7'd0;
            end else begin
                phase_d   = phase_q;
                sec_cnt_d = n_s;
            end
        end else begin
            phase_d   = phase_q;
            sec_cnt_d = sec_cnt_q;
        end
    end

    // Request latches: clearing on green entry takes priority over a simultaneous set.
    always_comb begin
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        if ((phase_d == PH_G1) && (phase_q != PH_G1)) begin
            pend1_d = 1'b0;
        end else if (req1 && (phase_q != PH_G1)) begin
            pend1_d = 1'b1;
        end else begin
            pend1_d = pend1_q;
        end
        if ((phase_d == PH_G2) && (phase_q != PH_G2)) begin
            pend2_d = 1'b0;
        end else if (req2 && (phase_q != PH_G2)) begin
            pend2_d = 1'b1;
        end else begin
            pend2_d = pend2_q;
        end
    end

    // Display and lamp values are derived from the next state so they change on the same edge as the phase.
    always_comb begin
        remain_d = phase_duration(phase_d) - sec_cnt_d;
        lamps_d  = lamp_decode(phase_d);
    end

    // State registers; reset parks the intersection in all-red with counters cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            phase_q   <= PH_AR2;
            sec_cnt_q <= 7'd0;
            remain_q  <= ARED_C;
            lamps_q   <= LAMPS_ALLRED;
            pend1_q   <= 1'b0;
            pend2_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            sec_cnt_q <= sec_cnt_d;
            remain_q  <= remain_d;
            lamps_q   <= lamps_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
        end
    end

    assign {R1_led, Y1_led, G1_led, R2_led, Y2_led, G2_led} = lamps_q;
    assign phase    = phase_q;
    assign remain   = remain_q;
    assign tick     = tick_q;
    assign bcd_tens = 4'(remain_q / 7'd10);
    assign bcd_ones = 4'(remain_q % 7'd10);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl (TICK_DIV=4, GREEN_MIN=2,
// GREEN_MAX=5, YELLOW_T=2, ALLRED_T=1), plus a second instance with a
// 25-second green for the two-digit BCD outputs.
module tb_traffic_phase_ctrl;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic       req1;
    logic       req2;
    logic       r1, y1, g1, r2, y2, g2;
    logic [2:0] phase;
    logic [6:0] remain;
    logic [3:0] tens, ones;
    logic       tick;
    logic       r1_b, y1_b, g1_b, r2_b, y2_b, g2_b;
    logic [2:0] phase_b;
    logic [6:0] remain_b;
    logic [3:0] tens_b, ones_b;
    logic       tick_b;

    int checks;
    int errors;

    traffic_phase_ctrl #(
        .TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(5), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2),
        .R1_led(r1), .Y1_led(y1), .G1_led(g1),
        .R2_led(r2), .Y2_led(y2), .G2_led(g2),
        .phase(phase), .remain(remain), .bcd_tens(tens), .bcd_ones(ones),
        .tick(tick)
    );

    traffic_phase_ctrl #(
        .TICK_DIV(4), .GREEN_MIN(25), .GREEN_MAX(25), .YELLOW_T(2), .ALLRED_T(1)
    ) dut_wide (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2),
        .R1_led(r1_b), .Y1_led(y1_b), .G1_led(g1_b),
        .R2_led(r2_b), .Y2_led(y2_b), .G2_led(g2_b),
        .phase(phase_b), .remain(remain_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps {R1,Y1,G1,R2,Y2,G2} for a phase code.
    function automatic logic [5:0] exp_lamps(input int code);
        case (code)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            3:       return 6'b100_001;
            4:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL reset_phase got %0d exp 5", phase); end
        checks++; if ({r1, y1, g1, r2, y2, g2} !== 6'b100_100) begin errors++; $display("FAIL reset_lamps got %b exp 100100", {r1, y1, g1, r2, y2, g2}); end
        checks++; if (remain !== 7'd1) begin errors++; $display("FAIL reset_remain got %0d exp 1", remain); end
        checks++; if ({tens, ones} !== 8'h01) begin errors++; $display("FAIL reset_bcd got %0d/%0d exp 0/1", tens, ones); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b exp 1", tick); end
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL pre_g1_phase got %0d exp 5", phase); end
        @(negedge clk);
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL g1_entry_phase got %0d exp 0", phase); end
        checks++; if ({r1, y1, g1, r2, y2, g2} !== 6'b001_100) begin errors++; $display("FAIL g1_entry_lamps got %b exp 001100", {r1, y1, g1, r2, y2, g2}); end
        checks++; if (remain !== 7'd5) begin errors++; $display("FAIL g1_entry_remain got %0d exp 5", remain); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL g1_entry_tick got %b exp 0", tick); end
    endtask

    task automatic test_full_cycle();
        int codes [6] = '{0, 1, 2, 3, 4, 5};
        int lens  [6] = '{20, 8, 4, 20, 8, 4};
        int durs  [6] = '{5, 2, 1, 5, 2, 1};
        int cnt;
        for (int i = 0; i < 6; i++) begin
            cnt = 0;
            while ((int'(phase) == codes[i]) && (cnt < 100)) begin
                checks++; if (remain !== 7'(durs[i] - cnt / TD)) begin errors++; $display("FAIL cycle_remain ph %0d clk %0d got %0d exp %0d", codes[i], cnt, remain, durs[i] - cnt / TD); end
                checks++; if ({r1, y1, g1, r2, y2, g2} !== exp_lamps(codes[i])) begin errors++; $display("FAIL cycle_lamps ph %0d got %b exp %b", codes[i], {r1, y1, g1, r2, y2, g2}, exp_lamps(codes[i])); end
                checks++; if ((int'(r1) + int'(y1) + int'(g1) != 1) || (int'(r2) + int'(y2) + int'(g2) != 1)) begin errors++; $display("FAIL one_lamp_per_road got %b exp one per road", {r1, y1, g1, r2, y2, g2}); end
                @(negedge clk);
                cnt++;
            end
            checks++; if (cnt != lens[i]) begin errors++; $display("FAIL cycle_len ph %0d got %0d exp %0d", codes[i], cnt, lens[i]); end
        end
    endtask

    task automatic test_actuated_g1();
        int codes [3] = '{0, 1, 2};
        int lens  [3] = '{8, 8, 4};
        int durs  [3] = '{5, 2, 1};
        int cnt;
        checks++; if (remain !== 7'd5) begin errors++; $display("FAIL act_start_remain got %0d exp 5", remain); end
        req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt = (i == 0) ? 1 : 0;
            while ((int'(phase) == codes[i]) && (cnt < 100)) begin
                checks++; if (remain !== 7'(durs[i] - cnt / TD)) begin errors++; $display("FAIL act_remain ph %0d clk %0d got %0d exp %0d", codes[i], cnt, remain, durs[i] - cnt / TD); end
                @(negedge clk);
                cnt++;
            end
            checks++; if (cnt != lens[i]) begin errors++; $display("FAIL act_len ph %0d got %0d exp %0d", codes[i], cnt, lens[i]); end
        end
    endtask

    task automatic test_req2_held();
        int codes [4] = '{3, 4, 5, 0};
        int lens  [4] = '{20, 8, 4, 20};
        int cnt;
        req2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            while ((int'(phase) == codes[i]) && (cnt < 100)) begin
                @(negedge clk);
                cnt++;
            end
            if (i == 0) req2 = 1'b0;
            checks++; if (cnt != lens[i]) begin errors++; $display("FAIL held_len ph %0d got %0d exp %0d", codes[i], cnt, lens[i]); end
        end
    endtask

    task automatic test_req1_actuated();
        int codes [6] = '{1, 2, 3, 4, 5, 0};
        int lens  [6] = '{8, 4, 8, 8, 4, 20};
        int durs  [6] = '{2, 1, 5, 2, 1, 5};
        int cnt;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cnt = (i == 0) ? 1 : 0;
            while ((int'(phase) == codes[i]) && (cnt < 100)) begin
                checks++; if (remain !== 7'(durs[i] - cnt / TD)) begin errors++; $display("FAIL req1_remain ph %0d clk %0d got %0d exp %0d", codes[i], cnt, remain, durs[i] - cnt / TD); end
                @(negedge clk);
                cnt++;
            end
            checks++; if (cnt != lens[i]) begin errors++; $display("FAIL req1_len ph %0d got %0d exp %0d", codes[i], cnt, lens[i]); end
        end
    endtask

    task automatic test_reset_mid_phase();
        repeat (2) @(negedge clk);
        checks++; if ({phase, y1} !== {3'd1, 1'b1}) begin errors++; $display("FAIL mid_pre_state got ph %0d y1 %b exp ph 1 y1 1", phase, y1); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({r1, y1, g1, r2, y2, g2} !== 6'b100_100) begin errors++; $display("FAIL mid_reset_lamps got %b exp 100100", {r1, y1, g1, r2, y2, g2}); end
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL mid_reset_phase got %0d exp 5", phase); end
        checks++; if (remain !== 7'd1) begin errors++; $display("FAIL mid_reset_remain got %0d exp 1", remain); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_reset_tick got %b exp 0", tick); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_early_tick got %b exp 0", tick); end
        @(negedge clk);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL mid_restart_tick got %b exp 1", tick); end
        @(negedge clk);
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_g1_phase got %0d exp 0", phase); end
        checks++; if (remain !== 7'd5) begin errors++; $display("FAIL mid_g1_remain got %0d exp 5", remain); end
    endtask

    task automatic test_bcd_two_digit();
        checks++; if (phase_b !== 3'd0) begin errors++; $display("FAIL wide_phase got %0d exp 0", phase_b); end
        checks++; if (remain_b !== 7'd25) begin errors++; $display("FAIL wide_remain25 got %0d exp 25", remain_b); end
        checks++; if ({tens_b, ones_b} !== 8'h25) begin errors++; $display("FAIL wide_bcd25 got %0d/%0d exp 2/5", tens_b, ones_b); end
        repeat (60) @(negedge clk);
        checks++; if (remain_b !== 7'd10) begin errors++; $display("FAIL wide_remain10 got %0d exp 10", remain_b); end
        checks++; if ({tens_b, ones_b} !== 8'h10) begin errors++; $display("FAIL wide_bcd10 got %0d/%0d exp 1/0", tens_b, ones_b); end
        repeat (4) @(negedge clk);
        checks++; if (remain_b !== 7'd9) begin errors++; $display("FAIL wide_remain9 got %0d exp 9", remain_b); end
        checks++; if ({tens_b, ones_b} !== 8'h09) begin errors++; $display("FAIL wide_bcd9 got %0d/%0d exp 0/9", tens_b, ones_b); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req1   = 1'b0;
        req2   = 1'b0;
        test_reset();
        test_full_cycle();
        test_actuated_g1();
        test_req2_held();
        test_req1_actuated();
        test_reset_mid_phase();
        test_bcd_two_digit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Sequencing controller for a two-road intersection: drives R/Y/G lamps for road 1 and road 2 through a fixed six-phase cycle.
- Green time is vehicle-actuated: a green ends early once the minimum has elapsed and the opposing road has a latched request.
- Exports the remaining seconds of the current phase as a binary count and as two BCD digits, for the separate 7-segment scan/mux block.
- Sits between the board's buttons/sensors and the display and lamp outputs.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1-second tick (bench uses 4).
- GREEN_MIN, 5, minimum green, in ticks (>=1).
- GREEN_MAX, 15, maximum green, in ticks (GREEN_MIN <= GREEN_MAX <= 99).
- YELLOW_T, 3, yellow duration, in ticks (1..99).
- ALLRED_T, 1, all-red clearance, in ticks (1..99).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req1  in  1  road-1 vehicle request, level, synchronous to clk.
- req2  in  1  road-2 vehicle request, level, synchronous to clk.
- R1_led, Y1_led, G1_led  out  1 each  road-1 lamps, registered.
- R2_led, Y2_led, G2_led  out  1 each  road-2 lamps, registered.
- phase  out  3  current phase code, registered.
- remain  out  7  seconds left in current phase, registered.
- bcd_tens  out  4  tens digit of remain.
- bcd_ones  out  4  units digit of remain.
- tick  out  1  one-clk pulse on each 1-second tick.

Behaviour:
- Prescaler: 0..TICK_DIV-1, free-running. tick=1 in the cycle the prescaler equals TICK_DIV-1; it then wraps to 0.
- Phases (codes): G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5. Codes 6 and 7 go to AR2 on the next clk.
- Lamps per phase:
  - G1: G1_led=1, R2_led=1.
  - Y1: Y1_led=1, R2_led=1.
  - AR1, AR2: R1_led=1, R2_led=1.
  - G2: R1_led=1, G2_led=1.
  - Y2: R1_led=1, Y2_led=1.
  - All other lamps are 0. Exactly one lamp per road is ever lit.
- sec_cnt (7 b): cleared on every phase entry; increments on tick. Let n = sec_cnt+1. All transition checks use n and are evaluated only in tick cycles.
  - G1->Y1 when n>=GREEN_MAX, or (n>=GREEN_MIN and pend2).
  - Y1->AR1 when n>=YELLOW_T.
  - AR1->G2 when n>=ALLRED_T.
  - G2, Y2, AR2 mirror G1, Y1, AR1, using pend1; AR2->G1.
- Request latches:
  - pend2 sets on any clk where req2=1 and phase!=G2, and clears on the clk entering G2. Set and clear in the same cycle: clear wins.
  - pend1 is symmetric (set when phase!=G1, cleared on entering G1).
  - The latches only shorten greens. With no requests the cycle still rotates at GREEN_MAX.
- Display outputs:
  - remain = duration(phase) - sec_cnt, where duration is GREEN_MAX, YELLOW_T or ALLRED_T.
  - remain updates on the same edge as phase/sec_cnt.
  - bcd_tens = remain/10 and bcd_ones = remain%10, combinational from the registered remain.
  - An actuated early exit makes remain jump from its current value straight to YELLOW_T.
- Latency: a transition decided in a tick cycle is visible on lamps/phase/remain after that clk edge (1 cycle).
- Reset (async, any time, including mid-phase):
  - phase=AR2, sec_cnt=0, prescaler=0, pend1=pend2=0.
  - Lamps: R1=R2=1, all others 0. remain=ALLRED_T, tick=0.
  - After release, the first tick moves to G1 when ALLRED_T=1.

Test Plan (TICK_DIV=4, GREEN_MIN=2, GREEN_MAX=5, YELLOW_T=2, ALLRED_T=1):
- Reset low, then release -> R1=R2=1, phase=5, remain=1, bcd=0/1. 4 clks after release: G1=1, R2=1, phase=0, remain=5.
- No requests, full cycle -> G1 20 clks, Y1 8, AR1 4, G2 20, Y2 8, AR2 4; remain counts 5,4,3,2,1 in G1. Never two lamps on one road.
- 1-clk req2 pulse in first G1 second -> Y1 entered at the 2nd tick (8 clks into G1). remain goes 5, 4, then 2 (Y1). pend2 cleared on G2 entry.
- req2 held high through G2 -> pend2 never set. G2 lasts the full 5 ticks; next G1 runs 5 ticks unless req2 is reasserted after G2.
- reset asserted 2 clks into Y1 -> same cycle: Y1_led=0, R1=R2=1, phase=5. On release the prescaler restarts from 0.
- GREEN_MAX=25, GREEN_MIN=25 -> G1 entry gives remain=25, bcd_tens=2, bcd_ones=5. After 16 ticks: remain=9, tens=0, ones=9.
